fu_wb_arbiter: RTL

- Collects results from NUM_FU functional units (the ctrl-side outputs of each fu_if) and serialises them onto one writeback/CDB port.
- One skid register per FU; round-robin grant among occupied registers; per-FU hold signal backpressures FUs whose result is still waiting.
- Sits between the FU array and the ROB/PRF writeback path.

---
 rtl/fu_wb_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter
//   Collects results from NUM_FU functional units and serialises them onto a
//   single writeback/CDB port. Each FU owns one skid buffer. A round-robin
//   grant runs over the occupied buffers. A combinational per-FU hold stops an
//   FU from presenting a new result while its buffered result is still waiting.
//
// Ports
//   clk, rst                clock, asynchronous active-low reset
//   fu_out_valid[i]         FU i presents a result this cycle
//   fu_out_inst_id[i]       instruction ID of that result
//   fu_out_prn[i][k]        destination PRN for result slot k
//   fu_out_data[i][k]       data for result slot k
//   fu_out_data_valid[i][k] valid for result slot k
//   fu_hold[i]              FU i must not present a new result this cycle
//   cdb_valid / cdb_ready   writeback handshake
//   cdb_src                 index of the FU being written back
//   cdb_inst_id, cdb_prn, cdb_data, cdb_data_valid
//                           granted payload, driven to 0 while cdb_valid=0
//   err_overflow            sticky; set when a result arrives at a held FU
//
// Optional build macro FU_WB_ARB_PERF_EN adds:
//   perf_clr                synchronous clear of all wait counters
//   perf_wait_cycles[i]     saturating count of cycles FU i's result waited
module fu_wb_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int DATA_W       = 64
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef FU_WB_ARB_PERF_EN
  input  logic                       perf_clr,
  output logic [31:0]                perf_wait_cycles [NUM_FU],
`endif
  input  logic                       fu_out_valid      [NUM_FU],
  input  logic [INST_ID_BITS-1:0]    fu_out_inst_id    [NUM_FU],
  input  logic [PRN_BITS-1:0]        fu_out_prn        [NUM_FU][MAX_OPERANDS],
  input  logic [DATA_W-1:0]          fu_out_data       [NUM_FU][MAX_OPERANDS],
  input  logic                       fu_out_data_valid [NUM_FU][MAX_OPERANDS],
  output logic                       fu_hold           [NUM_FU],
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output logic [$clog2(NUM_FU)-1:0]  cdb_src,
  output logic [INST_ID_BITS-1:0]    cdb_inst_id,
  output logic [PRN_BITS-1:0]        cdb_prn           [MAX_OPERANDS],
  output logic [DATA_W-1:0]          cdb_data          [MAX_OPERANDS],
  output logic                       cdb_data_valid    [MAX_OPERANDS],
  output logic                       err_overflow
);

  localparam int SRC_W = $clog2(NUM_FU);

  // Skid buffer contents, one entry per FU
  logic [NUM_FU-1:0]       vld_p0;
  logic [INST_ID_BITS-1:0] buf_inst_id_p0 [NUM_FU];
  logic [PRN_BITS-1:0]     buf_prn_p0     [NUM_FU][MAX_OPERANDS];
  logic [DATA_W-1:0]       buf_data_p0    [NUM_FU][MAX_OPERANDS];
  logic                    buf_dv_p0      [NUM_FU][MAX_OPERANDS];

  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  sel;
  logic              found;
  logic              transfer;
  logic [NUM_FU-1:0] drain;
  logic [NUM_FU-1:0] capture;
  logic [NUM_FU-1:0] hold;
  logic [NUM_FU-1:0] overflow_hit;

  // Successor of a round-robin index with wrap at NUM_FU-1; works for
  // non-power-of-two NUM_FU where plain binary wrap would not.
  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] p);
    if (p == SRC_W'(NUM_FU - 1)) return '0;
    else                         return p + SRC_W'(1);
  endfunction

  // Round-robin search: first occupied buffer at or after rr_ptr.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && vld_p0[idx]) begin
        found = 1'b1;
        sel   = SRC_W'(idx);
      end
    end
  end

  assign cdb_valid = |vld_p0;
  assign transfer  = cdb_valid && cdb_ready;

  // Drain/capture/hold per FU. Hold depends on cdb_ready so that a buffer
  // being drained this cycle can accept its FU's next result without a bubble.
  always_comb begin
    drain        = '0;
    capture      = '0;
    hold         = '0;
    overflow_hit = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      drain[i]        = transfer && (sel == SRC_W'(i));
      hold[i]         = vld_p0[i] && !drain[i];
      capture[i]      = fu_out_valid[i] && !hold[i];
      overflow_hit[i] = fu_out_valid[i] && hold[i];
      fu_hold[i]      = hold[i];
    end
  end

  // Granted payload; forced to zero whenever nothing is buffered.
  always_comb begin
    cdb_src     = '0;
    cdb_inst_id = '0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      cdb_prn[k]        = '0;
      cdb_data[k]       = '0;
      cdb_data_valid[k] = 1'b0;
    end
    if (cdb_valid) begin
      cdb_src     = sel;
      cdb_inst_id = buf_inst_id_p0[sel];
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        cdb_prn[k]        = buf_prn_p0[sel][k];
        cdb_data[k]       = buf_data_p0[sel][k];
        cdb_data_valid[k] = buf_dv_p0[sel][k];
      end
    end
  end

  // ---- stage p0: skid buffer occupancy, arbitration pointer, error flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0       <= '0;
      rr_ptr       <= '0;
      err_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (capture[i])    vld_p0[i] <= 1'b1;
        else if (drain[i]) vld_p0[i] <= 1'b0;
      end
      if (transfer)       rr_ptr       <= next_ptr(sel);
      if (|overflow_hit)  err_overflow <= 1'b1;
    end
  end

  // ---- stage p0: skid buffer payload (no reset; qualified by vld_p0) ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (capture[i]) begin
        buf_inst_id_p0[i] <= fu_out_inst_id[i];
        for (int k = 0; k < MAX_OPERANDS; k++) begin
          buf_prn_p0[i][k]  <= fu_out_prn[i][k];
          buf_data_p0[i][k] <= fu_out_data[i][k];
          buf_dv_p0[i][k]   <= fu_out_data_valid[i][k];
        end
      end
    end
  end

`ifdef FU_WB_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) return v;
    else                    return v + 32'd1;
  endfunction

  // ---- stage p0: wait-cycle counters (a held buffer counts as waiting) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) perf_wait_cycles[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (perf_clr)     perf_wait_cycles[i] <= '0;
        else if (hold[i]) perf_wait_cycles[i] <= sat_inc(perf_wait_cycles[i]);
      end
    end
  end
`endif

endmodule
